// File: rtl/dmem_burst_master.sv
// Burst master for a single-port synchronous data memory: turns one
// command (base address, length, direction) into a stream of memory accesses.
`ifndef DMEM_ADDR_WIDTH
`define DMEM_ADDR_WIDTH 8
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module dmem_burst_master #(
  parameter int unsigned BURST_W = 4,
  localparam int unsigned AW = `DMEM_ADDR_WIDTH,
  localparam int unsigned DW = `DATA_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_we,
  input  logic [AW-1:0]      cmd_addr,
  input  logic [BURST_W-1:0] cmd_len,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [DW-1:0]      wr_data,
  output logic               rd_valid,
  input  logic               rd_ready,
  output logic [DW-1:0]      rd_data,
  output logic               done,
  output logic [AW-1:0]      mem_addr,
  output logic [DW-1:0]      mem_din,
  output logic               mem_we,
  input  logic [DW-1:0]      mem_dout
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR      = 3'd1,
    RD_ADDR = 3'd2,
    RD_CAP  = 3'd3,
    RD_OUT  = 3'd4
  } state_t;

  state_t             state, state_n;
  logic [AW-1:0]      addr_r, addr_n;
  logic [BURST_W-1:0] cnt_r, cnt_n;
  logic [DW-1:0]      rd_data_n;
  logic               done_n;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      addr_r  <= '0;
      cnt_r   <= '0;
      rd_data <= '0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      addr_r  <= addr_n;
      cnt_r   <= cnt_n;
      rd_data <= rd_data_n;
      done    <= done_n;
    end
  end

  // Next-state and datapath update; done is set on the final beat handshake
  always_comb begin
    state_n   = state;
    addr_n    = addr_r;
    cnt_n     = cnt_r;
    rd_data_n = rd_data;
    done_n    = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          addr_n  = cmd_addr;
          cnt_n   = cmd_len;
          state_n = cmd_we ? WR : RD_ADDR;
        end
      end
      WR: begin
        if (wr_valid) begin
          addr_n = addr_r + AW'(1);
          cnt_n  = cnt_r - BURST_W'(1);
          if (cnt_r == '0) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end
        end
      end
      RD_ADDR: state_n = RD_CAP;
      RD_CAP: begin
        rd_data_n = mem_dout;
        state_n   = RD_OUT;
      end
      RD_OUT: begin
        if (rd_ready) begin
          if (cnt_r == '0) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end else begin
            addr_n  = addr_r + AW'(1);
            cnt_n   = cnt_r - BURST_W'(1);
            state_n = RD_ADDR;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Handshake and memory-port outputs are gated by rst so nothing leaks during reset
  assign cmd_ready = (state == IDLE) && !rst;
  assign wr_ready  = (state == WR) && !rst;
  assign rd_valid  = (state == RD_OUT) && !rst;
  assign mem_we    = (state == WR) && wr_valid && !rst;
  assign mem_addr  = addr_r;
  assign mem_din   = wr_data;

endmodule

// File: tb/tb_dmem_burst_master.sv
// Randomized scoreboard bench for dmem_burst_master against a word-array
// reference memory; a negedge monitor checks every write beat, read beat and done.
`ifndef DMEM_ADDR_WIDTH
`define DMEM_ADDR_WIDTH 8
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module tb_dmem_burst_master;
  localparam int unsigned AW = `DMEM_ADDR_WIDTH;
  localparam int unsigned DW = `DATA_WIDTH;
  localparam int unsigned BW = 4;

  logic          clk, rst;
  logic          cmd_valid, cmd_ready, cmd_we;
  logic [AW-1:0] cmd_addr;
  logic [BW-1:0] cmd_len;
  logic          wr_valid, wr_ready;
  logic [DW-1:0] wr_data;
  logic          rd_valid, rd_ready;
  logic [DW-1:0] rd_data;
  logic          done;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din, mem_dout;
  logic          mem_we;

  dmem_burst_master #(.BURST_W(BW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .done(done),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_dout(mem_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read memory driven by the DUT
  logic [DW-1:0] mem [2**AW];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_din;
    mem_dout <= mem[mem_addr];
  end

  // Reference contents: what every address should hold once queued writes land
  logic [DW-1:0] ref_mem [2**AW];

  typedef struct packed {
    logic          rd;
    logic          last;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;
  exp_t q[$];

  int   checks = 0;
  int   errors = 0;
  logic done_due = 1'b0;

  task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic flag(input string nm);
    checks++;
    errors++;
    $display("FAIL %s at %0t", nm, $time);
  endtask

  // Monitor: pops the scoreboard whenever the DUT writes memory or completes a read beat
  always @(negedge clk) begin
    exp_t e;
    if (done || done_due) chk("done", 64'(done), 64'(done_due));
    done_due = 1'b0;
    if (rst) begin
      chk("rst_outputs", 64'({cmd_ready, wr_ready, rd_valid, mem_we}), 64'd0);
    end else begin
      if (mem_we) begin
        if (q.size() == 0 || q[0].rd) begin
          flag("spurious_mem_we");
        end else begin
          e = q.pop_front();
          chk("wr_addr", 64'(mem_addr), 64'(e.addr));
          chk("wr_data", 64'(mem_din), 64'(e.data));
          done_due = e.last;
        end
      end
      if (rd_valid) begin
        if (q.size() == 0 || !q[0].rd) begin
          flag("spurious_rd_valid");
        end else begin
          chk("rd_data", 64'(rd_data), 64'(q[0].data));
          chk("rd_addr_hold", 64'(mem_addr), 64'(q[0].addr));
          if (rd_ready) begin
            e = q.pop_front();
            done_due = e.last;
          end
        end
      end
    end
  end

  task automatic issue(input logic we, input logic [AW-1:0] a, input int len);
    logic ok;
    int   budget;
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_addr  = a;
    cmd_len   = BW'(len);
    budget    = 0;
    do begin
      @(negedge clk);
      ok = cmd_ready;
      @(posedge clk);
      #1;
      budget++;
    end while (!ok && budget < 50);
    cmd_valid = 1'b0;
    cmd_we    = 1'($urandom);
    cmd_addr  = AW'($urandom);
    if (!ok) flag("cmd_accept_timeout");
  endtask

  // gap_mode: 0 none, 1 one idle cycle before each beat, 2 random; abort_at < 0 means no reset
  task automatic write_burst(input logic [AW-1:0] a, input int len, input int gap_mode,
                             input logic dir, input logic [DW-1:0] dbase, input int abort_at);
    logic [DW-1:0] d[$];
    exp_t e;
    int   n, gap;
    logic ok;
    n = len + 1;
    for (int i = 0; i < n; i++) d.push_back(dir ? dbase + DW'(i) : DW'($urandom));
    for (int i = 0; i < n; i++) begin
      if (abort_at < 0 || i < abort_at) begin
        e.rd   = 1'b0;
        e.last = (i == n - 1);
        e.addr = a + AW'(i);
        e.data = d[i];
        q.push_back(e);
        ref_mem[e.addr] = d[i];
      end
    end
    issue(1'b1, a, len);
    for (int i = 0; i < n; i++) begin
      gap = (gap_mode == 1) ? 1 : (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
      repeat (gap) begin
        wr_valid = 1'b0;
        wr_data  = DW'($urandom);
        @(posedge clk);
        #1;
      end
      wr_valid = 1'b1;
      wr_data  = d[i];
      if (i == abort_at) begin
        rst = 1'b1;
        repeat (2) begin
          @(posedge clk);
          #1;
        end
        rst      = 1'b0;
        wr_valid = 1'b0;
        @(negedge clk);
        chk("cmd_ready_after_rst", 64'(cmd_ready), 64'd1);
        @(posedge clk);
        #1;
        return;
      end
      ok = wr_ready;
      @(posedge clk);
      #1;
      if (!ok) begin
        flag("wr_ready_low_in_burst");
        break;
      end
    end
    wr_valid = 1'b0;
  endtask

  // stall_mode: 0 none, 1 five cycles on beat 0, 2 random 0..3 per beat
  task automatic read_burst(input logic [AW-1:0] a, input int len, input int stall_mode);
    exp_t e;
    int   n, beat, s, lat, cycles;
    logic seen;
    n = len + 1;
    for (int i = 0; i < n; i++) begin
      e.rd   = 1'b1;
      e.last = (i == n - 1);
      e.addr = a + AW'(i);
      e.data = ref_mem[e.addr];
      q.push_back(e);
    end
    issue(1'b0, a, len);
    beat   = 0;
    lat    = 0;
    cycles = 0;
    seen   = 1'b0;
    s      = (stall_mode == 1) ? 5 : (stall_mode == 2) ? int'($urandom_range(0, 3)) : 0;
    while (beat < n && cycles < 500) begin
      lat++;
      if (rd_valid) begin
        if (!seen) chk("rd_latency", 64'(lat), 64'd3);
        seen = 1'b1;
        if (s > 0) begin
          rd_ready = 1'b0;
          s--;
        end else begin
          rd_ready = 1'b1;
          beat++;
          lat  = 0;
          seen = 1'b0;
          s    = (stall_mode == 2) ? int'($urandom_range(0, 3)) : 0;
        end
      end else begin
        rd_ready = 1'($urandom);
      end
      @(posedge clk);
      #1;
      cycles++;
    end
    rd_ready = 1'b0;
    if (beat < n) flag("rd_burst_timeout");
  endtask

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_we    = 1'b0;
    cmd_addr  = '0;
    cmd_len   = '0;
    wr_valid  = 1'b1;
    wr_data   = '0;
    rd_ready  = 1'b1;
    for (int i = 0; i < 2**AW; i++) ref_mem[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    rst      = 1'b0;
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    @(negedge clk);
    chk("reset_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("reset_addr", 64'(mem_addr), 64'd0);
    chk("reset_rd_data", 64'(rd_data), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    @(posedge clk);
    #1;

    // Populate the low region so every later read has known contents
    for (int k = 0; k < 4; k++) write_burst(AW'(16 * k), 15, 0, 1'b0, '0, -1);

    write_burst(AW'(8'h10), 3, 0, 1'b1, DW'(32'hA0), -1);
    read_burst(AW'(8'h10), 3, 0);
    read_burst(AW'(8'h10), 1, 1);

    write_burst(AW'(2**AW - 2), 3, 0, 1'b0, '0, -1);
    read_burst(AW'(2**AW - 2), 3, 0);

    write_burst(AW'(8'h20), 3, 1, 1'b0, '0, -1);
    read_burst(AW'(8'h20), 3, 2);

    write_burst(AW'(8'h30), 7, 0, 1'b0, '0, 2);
    read_burst(AW'(8'h30), 7, 0);

    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 1) == 1)
        write_burst(AW'($urandom_range(0, 48)), int'($urandom_range(0, 15)),
                    int'($urandom_range(0, 2)), 1'b0, '0, -1);
      else
        read_burst(AW'($urandom_range(0, 48)), int'($urandom_range(0, 15)),
                   int'($urandom_range(0, 2) == 1 ? 2 : 0));
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("scoreboard_drained", 64'(q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_burst_master.md
DMEM_BURST_MASTER -- requirements
Module: dmem_burst_master

Interface
REQ-001 SHALL have parameter BURST_W, default 4: width of cmd_len; bursts of 1..2^BURST_W beats.
REQ-002 SHALL take AW = `DMEM_ADDR_WIDTH and DW = `DATA_WIDTH from the codebase macros.
REQ-003 SHALL have clk  input  1  single clock; all logic on posedge.
REQ-004 SHALL have rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have cmd_valid  input  1  burst command offered.
REQ-006 SHALL have cmd_ready  output  1  command accepted when high with cmd_valid.
REQ-007 SHALL have cmd_we  input  1  1 = write burst, 0 = read burst.
REQ-008 SHALL have cmd_addr  input  AW  burst base word address.
REQ-009 SHALL have cmd_len  input  BURST_W  beats minus one.
REQ-010 SHALL have wr_valid / wr_ready / wr_data  input / output / input DW: write-data stream.
REQ-011 SHALL have rd_valid / rd_ready / rd_data  output / input / output DW: read-data stream.
REQ-012 SHALL have done  output  1  one-cycle pulse at burst completion.
REQ-013 SHALL have mem_addr / mem_din / mem_we  output AW / output DW / output 1: memory port drive.
REQ-014 SHALL have mem_dout  input  DW  memory read data; sync read, valid one cycle after address.

Function
REQ-015 SHALL implement states IDLE, WR, RD_ADDR, RD_CAP, RD_OUT.
REQ-016 SHALL assert cmd_ready only in IDLE.
REQ-017 SHALL latch cmd_addr into addr_r and cmd_len into cnt_r on cmd handshake; go to WR if cmd_we, else RD_ADDR.
REQ-018 SHALL drive mem_addr = addr_r in every state.
REQ-019 SHALL drive mem_din = wr_data combinationally.
REQ-020 SHALL drive mem_we = (state==WR && wr_valid && !rst), combinationally; mem_we is 0 in all other states.
REQ-021 In WR, SHALL assert wr_ready = 1.
REQ-022 On each WR beat (wr_valid&&wr_ready), SHALL increment addr_r and decrement cnt_r; when cnt_r==0 on that beat, SHALL go to IDLE.
REQ-023 SHALL not advance while wr_valid=0; no write pulse while stalled.
REQ-024 In RD_ADDR, SHALL present addr_r for one cycle, then go to RD_CAP.
REQ-025 In RD_CAP, SHALL register mem_dout into rd_data, then go to RD_OUT.
REQ-026 SHALL assert rd_valid only in RD_OUT.
REQ-027 SHALL hold rd_data stable until the rd_valid&&rd_ready handshake.
REQ-028 On read handshake, if cnt_r==0, SHALL go to IDLE; else SHALL increment addr_r, decrement cnt_r, and go to RD_ADDR.
REQ-029 Read throughput SHALL be 1 beat per 3 cycles minimum; first rd_valid appears 3 cycles after cmd handshake.
REQ-030 SHALL register done high for exactly the cycle after the final beat handshake (write or read), coincident with return to IDLE.
REQ-031 SHALL wrap addr_r modulo 2^AW: (2^AW-1)+1 = 0, with no error.
REQ-032 SHALL accept a new command in the IDLE cycle where done is high; back-to-back bursts need no gap cycle.
REQ-033 SHALL ignore wr_valid outside WR and rd_ready outside RD_OUT.
REQ-034 SHALL tolerate memory writes by another port during a read burst; data returned is the value captured in RD_CAP.

Reset
REQ-035 With rst high at a posedge: state=IDLE, addr_r=0, cnt_r=0, rd_data=0, done=0.
REQ-036 While rst is high, outputs SHALL be: cmd_ready=0, wr_ready=0, rd_valid=0, mem_we=0.
REQ-037 Reset mid-burst SHALL abandon the burst, with no done pulse and no further memory writes; cmd_ready=1 the first cycle after rst falls.

Verification
REQ-038 Write burst: addr=0x10, len=3, data 0xA0..0xA3 offered continuously -> mem_we high 4 consecutive cycles at 0x10..0x13, done pulses once.
REQ-039 Read burst: addr=0x10, len=3, rd_ready=1 -> rd_data 0xA0,0xA1,0xA2,0xA3 with rd_valid spaced 3 cycles apart, first 3 cycles after accept, then done.
REQ-040 Backpressure: read len=1 with rd_ready low 5 cycles on beat 0 -> rd_data held; mem_addr stays on beat 0; beats delivered in order.
REQ-041 Wrap: write addr=2^AW-2, len=3 -> writes land at 2^AW-2, 2^AW-1, 0, 1.
REQ-042 Write stall: wr_valid gapped 0,1,0,1 -> mem_we only on valid cycles; the address advances only on beats.
REQ-043 Reset during beat 2 of a len=7 write -> no further mem_we, no done, cmd_ready=1 after release; next command executes correctly.
